lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive matches in CHECK required to enter LOCKED.
REQ-002 Parameter LOSS_CNT, default 3: consecutive mismatches in LOCKED that force a return to HUNT.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_bit is sampled on the posedge where in_valid=1.
REQ-006 in_bit  input  1  serial bit from the 8-bit LFSR generator.
REQ-007 err_clr  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 bit_err  output  1  one-cycle pulse for each mismatching bit sampled in LOCKED.
REQ-010 err_cnt  output  8  saturating count of LOCKED mismatches.
REQ-011 zero_seen  output  1  sticky flag; an all-zero history was detected.
REQ-012 state  output  2  current FSM state: 0=HUNT, 1=CHECK, 2=LOCKED.
REQ-013 seg0  output  8  active-low hex glyph of err_cnt[3:0].
REQ-014 seg1  output  8  active-low hex glyph of err_cnt[7:4].

Function
REQ-015 Generator model: the generator state s steps as s <= {s[0]^s[2]^s[3]^s[4], s[7:1]} and emits s[0] each step.
REQ-016 History register H[7:0] shifts right with the new bit entering H[7], so H[0] is the oldest bit.
REQ-017 Expected bit: exp = H[0]^H[2]^H[3]^H[4].
REQ-018 Nothing changes on cycles with in_valid=0, except rst and err_clr.
REQ-019 HUNT operation: each valid bit does H <= {in_bit, H[7:1]} and increments fill (0..7).
REQ-020 HUNT exit: on the 8th valid bit, fill clears and the FSM moves to CHECK; no comparison is made in HUNT.
REQ-021 CHECK comparison: each valid bit is compared with exp, then H <= {in_bit, H[7:1]}.
REQ-022 CHECK match: increments match_cnt; at match_cnt=LOCK_CNT the FSM moves to LOCKED.
REQ-023 CHECK mismatch: clears match_cnt and the FSM stays in CHECK.
REQ-024 CHECK zero history: if H==8'h00 when a valid bit arrives, the FSM moves to HUNT, fill and match_cnt clear, and zero_seen is set; the bit is not compared.
REQ-025 LOCKED flywheel: each valid bit does H <= {exp, H[7:1]}, i.e. the expected bit is shifted in, not the received one.
REQ-026 LOCKED match: clears miss_cnt.
REQ-027 LOCKED mismatch: pulses bit_err the next cycle, increments err_cnt (saturating at 8'hFF) and increments miss_cnt.
REQ-028 Loss of lock: at miss_cnt=LOSS_CNT the FSM moves to HUNT, with fill, miss_cnt and match_cnt cleared.
REQ-029 All outputs are registered; locked, state and bit_err reflect a sampled bit on the cycle after that sample.
REQ-030 err_clr has priority over a simultaneous increment; err_cnt becomes 0.
REQ-031 err_clr does not affect the FSM state, H or zero_seen.
REQ-032 Glyph encoding: bit7=a through bit1=g, bit0=dp; dp is always off.
REQ-033 Glyph patterns before inversion: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110, A=11101110, b=00111110, C=10011100, d=01111010, E=10011110, F=10001110.
REQ-034 seg0 and seg1 are the inverted patterns and are updated together with err_cnt.

Reset
REQ-035 Reset state: state=HUNT; H, fill, match_cnt, miss_cnt and err_cnt are 0.
REQ-036 Reset outputs: locked=0, bit_err=0, zero_seen=0, seg0=seg1=8'h03.
REQ-037 rst asserted mid-operation, including in LOCKED, returns to the reset state on the next posedge and overrides in_valid and err_clr.

Structure
REQ-038 A shared package holds the state enum, the tap constant 8'b0001_1101 and the 16-entry glyph table.
REQ-039 One sub-module, hex7seg (4-bit in, 8-bit active-low out), is instantiated twice.

Verification
REQ-040 Seed 8'h01, 40 valid bits: state=CHECK after bit 8; locked=1 the cycle after bit 24; err_cnt=0; seg0=seg1=8'h03.
REQ-041 While locked, flip one bit: one bit_err pulse, err_cnt=1, seg0=8'h9F, locked stays 1, no further errors on the following 10 bits.
REQ-042 While locked, flip 3 consecutive bits: err_cnt=3, state=HUNT, locked=0 the cycle after the third flip; relock 24 bits later.
REQ-043 All-zero stream of 30 bits: zero_seen=1, locked never asserts, state returns to HUNT after bit 9.
REQ-044 Assert err_clr on the same cycle as a locked mismatch: err_cnt=0, bit_err still pulses; 300 forced mismatches with locked held by interleaved matches saturate err_cnt at 8'hFF, seg1=seg0=8'h71.
REQ-045 Assert rst while locked with err_cnt=5: next cycle all REQ-035/036 reset values hold.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg: shared FSM states, generator taps and seven-segment glyph table
package lfsr_checker_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [7:0] TAPS = 8'b0001_1101;
  localparam logic [7:0] GLYPHS [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };
  function automatic logic lfsr_exp(input logic [7:0] h);
    return ^(h & TAPS);
  endfunction
endpackage

// File: rtl/lfsr_checker_hex7seg.sv
// hex7seg: 4-bit value to active-low seven-segment glyph, dp off
module hex7seg
  import lfsr_checker_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [7:0] o_seg
);
  assign o_seg = ~GLYPHS[i_val];
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto an 8-bit LFSR bit stream and counts bit errors while locked
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       err_clr,
  output logic       locked,
  output logic       bit_err,
  output logic [7:0] err_cnt,
  output logic       zero_seen,
  output logic [1:0] state,
  output logic [7:0] seg0,
  output logic [7:0] seg1
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST = LW'(LOSS_CNT - 1);
  state_t          r_state;
  logic [7:0]      r_h;
  logic [2:0]      r_fill;
  logic [MW-1:0]   r_match;
  logic [LW-1:0]   r_miss;
  logic [7:0]      r_err, r_seg0, r_seg1;
  logic            r_locked, r_bit_err, r_zero;
  logic            w_exp, w_hit, w_mis;
  logic [7:0]      w_err_nxt, w_seg0, w_seg1;
  always_comb begin
    w_exp = lfsr_exp(r_h);
    w_hit = in_bit == w_exp;
    w_mis = in_valid && r_state == LOCKED && !w_hit;
    w_err_nxt = err_clr ? 8'h00 : (w_mis && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
  end
  // glyphs are decoded from the next count so they register alongside err_cnt
  hex7seg u_seg0 (.i_val(w_err_nxt[3:0]), .o_seg(w_seg0));
  hex7seg u_seg1 (.i_val(w_err_nxt[7:4]), .o_seg(w_seg1));
  assign locked    = r_locked;
  assign bit_err   = r_bit_err;
  assign err_cnt   = r_err;
  assign zero_seen = r_zero;
  assign state     = r_state;
  assign seg0      = r_seg0;
  assign seg1      = r_seg1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HUNT;
      r_h       <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_miss    <= '0;
      r_err     <= '0;
      r_seg0    <= ~GLYPHS[0];
      r_seg1    <= ~GLYPHS[0];
      r_locked  <= 1'b0;
      r_bit_err <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_err     <= w_err_nxt;
      r_seg0    <= w_seg0;
      r_seg1    <= w_seg1;
      r_bit_err <= w_mis;
      if (in_valid) begin
        case (r_state)
          HUNT: begin
            r_h    <= {in_bit, r_h[7:1]};
            r_fill <= r_fill + 3'd1;
            if (r_fill == 3'd7) r_state <= CHECK;
          end
          CHECK: begin
            if (r_h == 8'h00) begin
              r_state <= HUNT;
              r_fill  <= '0;
              r_match <= '0;
              r_zero  <= 1'b1;
            end else begin
              r_h <= {in_bit, r_h[7:1]};
              if (!w_hit) r_match <= '0;
              else if (r_match != MATCH_LAST) r_match <= r_match + 1'b1;
              else begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_match  <= '0;
                r_miss   <= '0;
              end
            end
          end
          LOCKED: begin
            // flywheel: regenerate locally so isolated errors do not corrupt history
            r_h <= {w_exp, r_h[7:1]};
            if (w_hit) r_miss <= '0;
            else if (r_miss != MISS_LAST) r_miss <= r_miss + 1'b1;
            else begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
              r_fill   <= '0;
              r_miss   <= '0;
              r_match  <= '0;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table-driven and scoreboarded checks of lfsr_checker lock, loss, errors and glyphs
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic rst, in_valid, in_bit, err_clr;
  logic locked, bit_err, zero_seen;
  logic [7:0] err_cnt, seg0, seg1;
  logic [1:0] state;
  typedef struct packed {logic [1:0] st; logic lk; logic be; logic zs; logic [7:0] ec;} exp_t;
  typedef struct {int n; logic flip; logic clr; exp_t e;} vec_t;
  localparam logic [7:0] SEG [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };
  exp_t sb[$];
  vec_t tbl[12];
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] g;
  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .err_clr(err_clr),
    .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .zero_seen(zero_seen),
    .state(state), .seg0(seg0), .seg1(seg1)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [1:0] st, input logic lk, be, zs, input logic [7:0] ec);
    return '{st: st, lk: lk, be: be, zs: zs, ec: ec};
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic gen(output logic b);
    b = g[0];
    g = {g[0] ^ g[2] ^ g[3] ^ g[4], g[7:1]};
  endtask
  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      chk("state", {6'd0, state}, {6'd0, e.st});
      chk("locked", {7'd0, locked}, {7'd0, e.lk});
      chk("bit_err", {7'd0, bit_err}, {7'd0, e.be});
      chk("zero_seen", {7'd0, zero_seen}, {7'd0, e.zs});
      chk("err_cnt", err_cnt, e.ec);
      chk("seg0", seg0, SEG[e.ec[3:0]]);
      chk("seg1", seg1, SEG[e.ec[7:4]]);
    end
  endtask
  task automatic send(input logic b, input logic clr, input exp_t e);
    if ($urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      err_clr  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_bit   = b;
    err_clr  = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    compare();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic b;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; err_clr = 1'b0; g = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(2'd0, 0, 0, 0, 8'h00));
    compare();
    rst = 1'b0;
    tbl = '{
      '{7,  1'b0, 1'b0, mk(2'd0, 0, 0, 0, 8'd0)},
      '{16, 1'b0, 1'b0, mk(2'd1, 0, 0, 0, 8'd0)},
      '{17, 1'b0, 1'b0, mk(2'd2, 1, 0, 0, 8'd0)},
      '{1,  1'b1, 1'b0, mk(2'd2, 1, 1, 0, 8'd1)},
      '{10, 1'b0, 1'b0, mk(2'd2, 1, 0, 0, 8'd1)},
      '{1,  1'b0, 1'b1, mk(2'd2, 1, 0, 0, 8'd0)},
      '{1,  1'b1, 1'b0, mk(2'd2, 1, 1, 0, 8'd1)},
      '{1,  1'b1, 1'b0, mk(2'd2, 1, 1, 0, 8'd2)},
      '{1,  1'b1, 1'b0, mk(2'd0, 0, 1, 0, 8'd3)},
      '{7,  1'b0, 1'b0, mk(2'd0, 0, 0, 0, 8'd3)},
      '{16, 1'b0, 1'b0, mk(2'd1, 0, 0, 0, 8'd3)},
      '{1,  1'b0, 1'b0, mk(2'd2, 1, 0, 0, 8'd3)}
    };
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        gen(b);
        send(b ^ tbl[i].flip, tbl[i].clr, tbl[i].e);
      end
    gen(b); send(~b, 1'b1, mk(2'd2, 1, 1, 0, 8'd0));
    gen(b); send(b, 1'b0, mk(2'd2, 1, 0, 0, 8'd0));
    for (int i = 1; i <= 300; i++) begin
      gen(b); send(~b, 1'b0, mk(2'd2, 1, 1, 0, i > 255 ? 8'hFF : 8'(i)));
      gen(b); send(b, 1'b0, mk(2'd2, 1, 0, 0, i > 255 ? 8'hFF : 8'(i)));
    end
    gen(b); send(b, 1'b1, mk(2'd2, 1, 0, 0, 8'd0));
    for (int i = 1; i <= 5; i++) begin
      gen(b); send(~b, 1'b0, mk(2'd2, 1, 1, 0, 8'(i)));
      gen(b); send(b, 1'b0, mk(2'd2, 1, 0, 0, 8'(i)));
    end
    in_valid = 1'b1; in_bit = 1'b1; err_clr = 1'b1; rst = 1'b1;
    sb.push_back(mk(2'd0, 0, 0, 0, 8'd0));
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
    compare();
    for (int k = 1; k <= 30; k++)
      send(1'b0, 1'b0, mk(k % 9 == 8 ? 2'd1 : 2'd0, 0, 0, k >= 9, 8'd0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
